// File: rtl/booth_r4_mul.sv
// rtl/booth_r4_mul.sv - radix-4 Booth sequential multiplier for MUL/MULH/MULHSU/MULHU
//
// Purpose: two's complement multiplier that retires two multiplier bits per
// cycle. Both operands are extended to XLEN+2 bits according to the op, so one
// datapath covers signed, mixed and unsigned products. The result is returned
// through a valid/result_ready handshake.
//
// Optional feature: define BOOTH_R4_ZERO_BYPASS_EN to let a zero operand skip
// the iteration phase and go straight to DONE with Z=0.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, accepted only while in_ready=1
//   op           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   X, Y         multiplicand (rs1), multiplier (rs2)
//   flush        synchronous abort of any in-flight operation
//   in_ready     high only in IDLE
//   valid        result available (DONE)
//   result_ready consumer accepts the result
//   Z            selected product half
module booth_r4_mul #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] Y,
  input  logic            flush,
  output logic            in_ready,
  output logic            valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] Z
);

  localparam int E  = XLEN + 2;        // extended operand width
  localparam int PW = XLEN + 3;        // partial-product / upper accumulator width
  localparam int N  = XLEN / 2 + 1;    // Booth iterations
  localparam int CW = $clog2(N + 1);

  if ((XLEN % 2) != 0 || XLEN < 8) begin : g_bad_xlen
    $error("booth_r4_mul: XLEN must be even and >= 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nx;
  logic [1:0]        op_q;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     hi;
  logic [E-1:0]      lo;
  logic              qm1;
  logic [CW-1:0]     count;

  logic              sign_x, sign_y, accept, last;
  logic [E-1:0]      x_ext, y_ext;
  logic [PW-1:0]     pp, sum;
  logic signed [PW+E-1:0] shifted;
  logic [2*XLEN-1:0] prod;
  logic [PW-XLEN+1:0] unused_hi;

  assign sign_x = (op == 2'b01) || (op == 2'b10);
  assign sign_y = (op == 2'b01);
  assign x_ext  = {{2{sign_x & X[XLEN-1]}}, X};
  assign y_ext  = {{2{sign_y & Y[XLEN-1]}}, Y};
  assign accept = (state == IDLE) && start && !flush;
  // count runs one past the last step: that extra cycle registers Z.
  assign last   = (count == CW'(N));

`ifdef BOOTH_R4_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (X == '0) || (Y == '0);
`endif

  // Recode the low multiplier triplet into a digit in {0, +-X, +-2X}.
  always_comb begin
    pp = '0;
    case ({lo[1:0], qm1})
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  assign sum     = hi + pp;
  assign shifted = $signed({sum, lo}) >>> 2;
  // After N steps {hi,lo} holds the full signed product; only 2*XLEN bits matter.
  assign prod      = {hi[XLEN-3:0], lo};
  assign unused_hi = hi[PW-1:XLEN-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef BOOTH_R4_ZERO_BYPASS_EN
          state_nx = zero_op ? DONE : BUSY;
`else
          state_nx = BUSY;
`endif
        end
      end
      BUSY: begin
        if (flush)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: begin
        if (flush || result_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    valid    = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      qm1   <= 1'b0;
      count <= '0;
      Z     <= '0;
    end else if (flush) begin
      count <= '0;
      Z     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            mcand <= {x_ext[E-1], x_ext};
            hi    <= '0;
            lo    <= y_ext;
            qm1   <= 1'b0;
            count <= '0;
`ifdef BOOTH_R4_ZERO_BYPASS_EN
            if (zero_op) Z <= '0;
`endif
          end
        end
        BUSY: begin
          if (last) begin
            Z <= (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end else begin
            hi    <= shifted[PW+E-1:E];
            lo    <= shifted[E-1:0];
            qm1   <= lo[1];
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
